envelope_follower: RTL

Amplitude-envelope detector for the synth's 16-bit signed sample stream. It rectifies and peak-holds incoming samples over fixed windows, then smooths the window peak with separate attack and release time constants. Each window it produces an unsigned envelope value and a phase code (rising, falling, steady or silent). It runs on the same per-sample `in_ready` strobe as the envelope generator and sits after it in the signal chain, recovering the amplitude contour that the generator imposed. Its outputs feed metering and auto-gain.

---
 rtl/envelope_follower.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/envelope_follower.sv
// envelope_follower: rectifies and peak-holds the sample stream over fixed
// windows of WINDOW samples, then smooths each window peak with separate
// attack/release shifts. One envelope value and phase code per window.
module envelope_follower #(
   parameter int unsigned WINDOW        = 480,
   parameter int unsigned ATTACK_SHIFT  = 1,
   parameter int unsigned RELEASE_SHIFT = 3,
   parameter logic [15:0] SILENCE_TH    = 16'd64,
   parameter logic [15:0] DELTA_TH      = 16'd256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] sample_in,
   input  logic        in_ready,
   output logic [15:0] envelope,
   output logic [1:0]  phase,
   output logic        env_valid
);

   localparam int unsigned   CW   = $clog2(WINDOW);
   localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);

   localparam logic [1:0] PH_RISING  = 2'd0;
   localparam logic [1:0] PH_FALLING = 2'd1;
   localparam logic [1:0] PH_STEADY  = 2'd2;
   localparam logic [1:0] PH_SILENT  = 2'd3;

   typedef enum logic {
      S_ACC = 1'b0,
      S_UPD = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] count_q;
   logic [15:0]   peak_q;
   logic [15:0]   peak_lat_q;
   logic [15:0]   env_q, env_d;
   logic [1:0]    phase_q, phase_d;
   logic          valid_q, valid_d;

   logic [15:0]   mag_s;
   logic [15:0]   peak_max_s;
   logic          close_s;
   logic [16:0]   rise_s, fall_s, step_s, new_env_s;
   logic [1:0]    phase_s;

   // Rectify the incoming sample; the most negative code saturates to +32767.
   always_comb begin
      mag_s = sample_in;
      if (sample_in == 16'h8000) begin
         mag_s = 16'h7FFF;
      end else if (sample_in[15]) begin
         mag_s = 16'd0 - sample_in;
      end else begin
         mag_s = sample_in;
      end
   end

   assign peak_max_s = (mag_s > peak_q) ? mag_s : peak_q;
   assign close_s    = in_ready && (count_q == LAST);

   // Window accumulator: running peak and sample count, latched on the closing sample.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q    <= '0;
         peak_q     <= 16'd0;
         peak_lat_q <= 16'd0;
      end else if (close_s) begin
         count_q    <= '0;
         peak_q     <= 16'd0;
         peak_lat_q <= peak_max_s;
      end else if (in_ready) begin
         count_q    <= count_q + {{(CW-1){1'b0}}, 1'b1};
         peak_q     <= peak_max_s;
      end
   end

   // Smoothing step toward the latched peak; never smaller than 1, never past the peak.
   always_comb begin
      rise_s    = {1'b0, peak_lat_q} - {1'b0, env_q};
      fall_s    = {1'b0, env_q} - {1'b0, peak_lat_q};
      step_s    = 17'd0;
      new_env_s = {1'b0, env_q};
      if (peak_lat_q > env_q) begin
         step_s    = rise_s >> ATTACK_SHIFT;
         if (step_s == 17'd0) begin
            step_s = 17'd1;
         end else begin
            step_s = step_s;
         end
         new_env_s = {1'b0, env_q} + step_s;
      end else if (peak_lat_q < env_q) begin
         step_s    = fall_s >> RELEASE_SHIFT;
         if (step_s == 17'd0) begin
            step_s = 17'd1;
         end else begin
            step_s = step_s;
         end
         new_env_s = {1'b0, env_q} - step_s;
      end else begin
         new_env_s = {1'b0, env_q};
      end
   end

   // Classify the update; the silence test takes priority over movement.
   always_comb begin
      phase_s = PH_STEADY;
      if (new_env_s < {1'b0, SILENCE_TH}) begin
         phase_s = PH_SILENT;
      end else if (new_env_s > ({1'b0, env_q} + {1'b0, DELTA_TH})) begin
         phase_s = PH_RISING;
      end else if ((new_env_s + {1'b0, DELTA_TH}) < {1'b0, env_q}) begin
         phase_s = PH_FALLING;
      end else begin
         phase_s = PH_STEADY;
      end
   end

   // FSM next state and output updates: UPD lasts exactly one cycle.
   always_comb begin
      state_d = state_q;
      env_d   = env_q;
      phase_d = phase_q;
      valid_d = 1'b0;
      case (state_q)
         S_ACC: begin
            if (close_s) begin
               state_d = S_UPD;
            end else begin
               state_d = S_ACC;
            end
         end
         S_UPD: begin
            state_d = S_ACC;
            env_d   = new_env_s[15:0];
            phase_d = phase_s;
            valid_d = 1'b1;
         end
         default: begin
            state_d = S_ACC;
         end
      endcase
   end

   // FSM state and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_ACC;
         env_q   <= 16'd0;
         phase_q <= PH_SILENT;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         env_q   <= env_d;
         phase_q <= phase_d;
         valid_q <= valid_d;
      end
   end

   assign envelope  = env_q;
   assign phase     = phase_q;
   assign env_valid = valid_q;

endmodule
